// File: rtl/cpu_run_controller.sv
// Program-load-and-run sequencer for the MIPS CPU. It fills instruction memory, seeds
// the register file, runs the CPU for a fixed cycle count, then checksums data memory.
module cpu_run_controller #(
  parameter int INSTR_MEM_SIZE = 32,
  parameter int DATA_MEM_SIZE  = 64,
  parameter int N_REGISTERS    = 32,
  parameter int CYCLE_WIDTH    = 16,
  parameter int IAW            = $clog2(INSTR_MEM_SIZE),
  parameter int DAW            = $clog2(DATA_MEM_SIZE),
  parameter int RAW            = $clog2(N_REGISTERS)
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   start_i,
  input  logic [IAW:0]           prog_len_i,
  input  logic [CYCLE_WIDTH-1:0] run_cycles_i,
  input  logic                   prog_valid_i,
  output logic                   prog_ready_o,
  input  logic [31:0]            prog_data_i,
  output logic                   imem_we_o,
  output logic [IAW-1:0]         imem_addr_o,
  output logic [31:0]            imem_wdata_o,
  output logic                   rf_we_o,
  output logic [RAW-1:0]         rf_addr_o,
  output logic [31:0]            rf_wdata_o,
  output logic [DAW-1:0]         dmem_addr_o,
  input  logic [31:0]            dmem_rdata_i,
  output logic                   cpu_reset_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [31:0]            checksum_o
);

  localparam int W0    = (IAW > RAW) ? IAW : RAW;
  localparam int W1    = (W0 > DAW) ? W0 : DAW;
  localparam int CNT_W = (W1 + 1 > CYCLE_WIDTH) ? W1 + 1 : CYCLE_WIDTH;

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [IAW:0]     len_t;
  typedef enum logic [2:0] {IDLE, LOAD, PAD, INIT, RUN, DUMP, DONE} state_e;

  localparam cnt_t CNT_ONE    = cnt_t'(1);
  localparam cnt_t IMEM_LAST  = cnt_t'(INSTR_MEM_SIZE - 1);
  localparam cnt_t RF_LAST    = cnt_t'(N_REGISTERS - 1);
  localparam cnt_t DMEM_LAST  = cnt_t'(DATA_MEM_SIZE - 1);
  localparam cnt_t DUMP_LAST  = cnt_t'(DATA_MEM_SIZE);
  localparam len_t IMEM_DEPTH = len_t'(INSTR_MEM_SIZE);

  state_e                 state_q;
  cnt_t                   cnt_q;
  len_t                   len_q;
  logic [CYCLE_WIDTH-1:0] runLen_q;
  logic [31:0]            checksum_q;
  logic                   progReady_q;
  logic                   padWe_q;
  logic                   rfWe_q;
  logic                   dumpEn_q;
  logic                   cpuReset_q;
  logic                   busy_q;
  logic                   done_q;

  len_t        len_d;
  logic [31:0] checksum_d;

  assign len_d      = (prog_len_i > IMEM_DEPTH) ? IMEM_DEPTH : prog_len_i;
  assign checksum_d = checksum_q + dmem_rdata_i;

  // One shared counter walks instruction addresses, register indices, run cycles and
  // dump addresses; it is only ever cleared when a state is left.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      len_q       <= '0;
      runLen_q    <= '0;
      checksum_q  <= '0;
      progReady_q <= 1'b0;
      padWe_q     <= 1'b0;
      rfWe_q      <= 1'b0;
      dumpEn_q    <= 1'b0;
      cpuReset_q  <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            len_q      <= len_d;
            runLen_q   <= run_cycles_i;
            cnt_q      <= '0;
            checksum_q <= '0;
            busy_q     <= 1'b1;
            if (len_d == '0) begin
              state_q <= PAD;
              padWe_q <= 1'b1;
            end else begin
              state_q     <= LOAD;
              progReady_q <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (prog_valid_i) begin
            if (cnt_q == cnt_t'(len_q) - CNT_ONE) begin
              progReady_q <= 1'b0;
              if (len_q == IMEM_DEPTH) begin
                state_q <= INIT;
                cnt_q   <= '0;
                rfWe_q  <= 1'b1;
              end else begin
                state_q <= PAD;
                cnt_q   <= cnt_q + CNT_ONE;
                padWe_q <= 1'b1;
              end
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end
        end
        PAD: begin
          if (cnt_q == IMEM_LAST) begin
            state_q <= INIT;
            cnt_q   <= '0;
            padWe_q <= 1'b0;
            rfWe_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        INIT: begin
          if (cnt_q == RF_LAST) begin
            cnt_q  <= '0;
            rfWe_q <= 1'b0;
            if (runLen_q == '0) begin
              state_q  <= DUMP;
              dumpEn_q <= 1'b1;
            end else begin
              state_q    <= RUN;
              cpuReset_q <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        RUN: begin
          if (cnt_q == cnt_t'(runLen_q) - CNT_ONE) begin
            state_q    <= DUMP;
            cnt_q      <= '0;
            cpuReset_q <= 1'b1;
            dumpEn_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        DUMP: begin
          // Read data trails the address by a cycle, so the first add is one cycle late.
          if (cnt_q != '0) checksum_q <= checksum_d;
          if (cnt_q == DMEM_LAST) dumpEn_q <= 1'b0;
          if (cnt_q == DUMP_LAST) begin
            state_q <= DONE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign prog_ready_o = progReady_q;
  assign imem_we_o    = padWe_q | (progReady_q & prog_valid_i);
  assign imem_addr_o  = (progReady_q | padWe_q) ? cnt_q[IAW-1:0] : '0;
  assign imem_wdata_o = progReady_q ? prog_data_i : '0;
  assign rf_we_o      = rfWe_q;
  assign rf_addr_o    = rfWe_q ? cnt_q[RAW-1:0] : '0;
  assign rf_wdata_o   = rfWe_q ? 32'(cnt_q[RAW-1:0]) : '0;
  assign dmem_addr_o  = dumpEn_q ? cnt_q[DAW-1:0] : '0;
  assign cpu_reset_o  = cpuReset_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign checksum_o   = checksum_q;

endmodule

// File: doc/cpu_run_controller.md
# cpu_run_controller

Synthesizable on-chip run controller for the MIPS CPU, the parametrised successor of the lab program-load-and-run bench flow.
- Streams a program into instruction memory and zero-pads the rest.
- Initialises the register file with register i = i, then releases the CPU from reset for a programmable cycle count.
- Sums all of data memory into a checksum and reports done.
- Sits beside CPU, wired to the instruction memory write port, register file write port and a data memory read port.

## Interface
- INSTR_MEM_SIZE, 32, instruction memory depth in words; IAW = clog2(INSTR_MEM_SIZE).
- DATA_MEM_SIZE, 64, data memory depth in words; DAW = clog2(DATA_MEM_SIZE).
- N_REGISTERS, 32, register file depth; RAW = clog2(N_REGISTERS).
- CYCLE_WIDTH, 16, width of the run-cycle count.
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  begin sequence; sampled only in IDLE.
- prog_len  in  IAW+1  number of program words; values above INSTR_MEM_SIZE are clamped.
- run_cycles  in  CYCLE_WIDTH  number of cycles the CPU runs.
- prog_valid / prog_ready / prog_data  in / out / in  1 / 1 / 32  program word stream.
- imem_we / imem_addr / imem_wdata  out  1 / IAW / 32  instruction memory write port.
- rf_we / rf_addr / rf_wdata  out  1 / RAW / 32  register file write port.
- dmem_addr  out  DAW  data memory read address.
- dmem_rdata  in  32  read data, valid one cycle after dmem_addr.
- cpu_reset  out  1  CPU reset; high in every state except RUN.
- busy  out  1  high outside IDLE and DONE.
- done  out  1  one-cycle pulse at end of sequence.
- checksum  out  32  data memory sum.

## Operation
- States: IDLE → LOAD → PAD → INIT → RUN → DUMP → DONE → IDLE.
- IDLE: start=1 latches min(prog_len, INSTR_MEM_SIZE) and run_cycles, clears the address counter and checksum, and moves to LOAD. start is ignored in every other state.
- LOAD: prog_ready=1. Each handshake (prog_valid & prog_ready) drives imem_we=1, imem_addr=counter, imem_wdata=prog_data in the same cycle, then increments the counter.
  - Stall (prog_valid=0): no write, no counter change.
  - On the last word, or immediately if latched length is 0, go to PAD.
- PAD: writes 0x00000000 (NOP) to each remaining address up to INSTR_MEM_SIZE-1, one per cycle. A full-length program skips PAD entirely; LOAD goes straight to INIT.
- INIT: rf_we=1, rf_addr=i, rf_wdata=i (zero-extended) for i = 0..N_REGISTERS-1, one per cycle.
- RUN: cpu_reset=0 for exactly the latched run_cycles cycles; all write enables are 0. If run_cycles=0, INIT goes directly to DUMP.
- DUMP: dmem_addr steps 0..DATA_MEM_SIZE-1, one per cycle. Each dmem_rdata is added to checksum one cycle later (sum mod 2^32, carry discarded). The state lasts DATA_MEM_SIZE+1 cycles.
- DONE: done=1 for one cycle, then return to IDLE. checksum holds until the next accepted start.
- Reset, at any time including mid-sequence:
  - next state is IDLE.
  - cpu_reset=1, checksum=0, all counters 0.
  - Partially written memories are left as they are.

## Timing
- Reset values: cpu_reset=1; every other output 0, including prog_ready, all write enables, addresses, write data, checksum, busy and done.
- Cycle 0 is the cycle in which start is sampled. LOAD begins in cycle 1.
- With no stalls, cycles are allocated as follows:
  - LOAD+PAD: INSTR_MEM_SIZE cycles.
  - INIT: N_REGISTERS cycles.
  - RUN: run_cycles cycles.
  - DUMP: DATA_MEM_SIZE+1 cycles.
- done is high in cycle INSTR_MEM_SIZE + N_REGISTERS + run_cycles + DATA_MEM_SIZE + 2. With defaults and run_cycles=6, that is cycle 136.
- Each prog_valid stall cycle adds exactly one cycle.
- cpu_reset falls on the first RUN cycle and rises on the first DUMP cycle.
- The counter wraps only at state exits; addresses never exceed their depth minus one.

## Test plan
- Reset, then start with prog_len=4, run_cycles=6, prog_valid always 1:
  - imem[0..3] = stream words; imem[4..31] = 0.
  - rf[i]=i for all 32 registers.
  - cpu_reset low for exactly 6 cycles.
  - done in cycle 136.
- prog_len=32: no PAD cycles, INIT begins in cycle 33. prog_len=40: clamped to 32, and prog_ready drops after the 32nd word.
- Deassert prog_valid for 3 cycles mid-LOAD: no imem_we during the stall, no address skip, and done is delayed by 3 cycles.
- run_cycles=0: cpu_reset never falls; DUMP follows INIT directly; done in cycle 130.
- dmem preloaded with mem[k]=k and then mem[63]=0xFFFFFFFF: checksum = 2016 + 0xFFFFFFFF − 63 mod 2^32 = 0x000007A0.
- Assert reset during INIT, and separately pulse start during RUN:
  - reset: immediate return to IDLE with cpu_reset=1 and checksum=0.
  - start during RUN: no effect.
